// File: rtl/am_audio_decimator.sv
// Decimates an unsigned AM envelope by block averaging, then removes DC with a
// leaky-integrator tracker and presents saturated signed audio behind a valid/ready hold register.
module am_audio_decimator #(
  parameter int INPUT_WIDTH = 12,
  parameter int DECIM_LOG2  = 6,
  parameter int DC_SHIFT    = 8
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [INPUT_WIDTH-1:0] env_in,
  input  logic                   env_valid,
  output logic [INPUT_WIDTH-1:0] audio_out,
  output logic                   audio_valid,
  input  logic                   audio_ready,
  output logic                   sat,
  output logic                   overrun
);

  localparam int AW = INPUT_WIDTH + DECIM_LOG2;
  localparam int DW = INPUT_WIDTH + DC_SHIFT;

  logic [AW-1:0]                acc;
  logic [AW-1:0]                acc_sum;
  logic [DECIM_LOG2-1:0]        cnt;
  logic                         block_done;
  logic [INPUT_WIDTH-1:0]       avg;
  logic                         avg_vld;

  logic [DW-1:0]                dc_acc;
  logic [DW-1:0]                dc_acc_eff;
  logic [DW-1:0]                dc_acc_next;
  logic                         seeded;
  logic [INPUT_WIDTH-1:0]       dc;
  logic signed [INPUT_WIDTH:0]  diff;
  logic                         clip_hi;
  logic                         clip_lo;
  logic [INPUT_WIDTH-1:0]       out_clip;
  logic [INPUT_WIDTH-1:0]       out_reg;
  logic                         out_sat;
  logic                         out_vld;

  assign acc_sum    = acc + AW'(env_in);
  assign block_done = env_valid && (cnt == '1);

  // Block accumulator; the last sample of a block folds straight into avg.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc     <= '0;
      cnt     <= '0;
      avg     <= '0;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= block_done;
      if (env_valid) begin
        cnt <= cnt + DECIM_LOG2'(1);
        if (block_done) begin
          avg <= acc_sum[AW-1:DECIM_LOG2];
          acc <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  // Until the first average arrives the tracker is seeded with it, so the first output is zero.
  always_comb begin
    dc_acc_eff  = seeded ? dc_acc : {avg, {DC_SHIFT{1'b0}}};
    dc          = dc_acc_eff[DW-1:DC_SHIFT];
    diff        = $signed({1'b0, avg}) - $signed({1'b0, dc});
    clip_hi     = diff > $signed({2'b00, {(INPUT_WIDTH-1){1'b1}}});
    clip_lo     = diff < $signed({2'b11, {(INPUT_WIDTH-1){1'b0}}});
    out_clip    = diff[INPUT_WIDTH-1:0];
    if (clip_hi) begin
      out_clip = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
    end else if (clip_lo) begin
      out_clip = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
    end
    dc_acc_next = dc_acc_eff + DW'(avg) - DW'(dc);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dc_acc  <= '0;
      seeded  <= 1'b0;
      out_reg <= '0;
      out_sat <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= avg_vld;
      if (avg_vld) begin
        seeded  <= 1'b1;
        dc_acc  <= dc_acc_next;
        out_reg <= out_clip;
        out_sat <= clip_hi | clip_lo;
      end
    end
  end

  // A load on a consume edge replaces the taken sample; a load onto an untaken one is an overrun.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      audio_out   <= '0;
      audio_valid <= 1'b0;
      sat         <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sat <= out_vld && out_sat;
      if (out_vld) begin
        audio_out   <= out_reg;
        audio_valid <= 1'b1;
        if (audio_valid && !audio_ready) begin
          overrun <= 1'b1;
        end
      end else if (audio_ready) begin
        audio_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_am_audio_decimator.sv
// Scoreboard bench for am_audio_decimator: a block-average / DC-tracker model queues
// expected samples as stimulus is driven; scenario tasks compare them with observed outputs.
module tb_am_audio_decimator;

  localparam int W = 12;
  localparam int D = 6;
  localparam int S = 8;
  localparam int N = 1 << D;

  logic         clk;
  logic         arst_n;
  logic [W-1:0] env_in;
  logic         env_valid;
  logic [W-1:0] audio_out;
  logic         audio_valid;
  logic         audio_ready;
  logic         sat;
  logic         overrun;

  am_audio_decimator #(
    .INPUT_WIDTH (W),
    .DECIM_LOG2  (D),
    .DC_SHIFT    (S)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .env_in      (env_in),
    .env_valid   (env_valid),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .audio_ready (audio_ready),
    .sat         (sat),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] val;
    logic         sat;
    logic [31:0]  edge_ix;
  } sample_t;

  sample_t exp_q[$];
  sample_t obs_q[$];

  int errors   = 0;
  int checks   = 0;
  int edge_cnt = 0;
  int base     = 0;

  int m_acc    = 0;
  int m_cnt    = 0;
  int m_dc_acc = 0;
  bit m_seeded = 0;

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_dc_acc = 0;
    m_seeded = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // One clock: model the accepted sample, advance, then record any sample handed over.
  task automatic step(input logic v, input logic [W-1:0] d);
    int avg;
    int dc;
    int o;
    logic s;
    env_valid = v;
    env_in    = d;
    if (v) begin
      m_acc += int'(d);
      m_cnt++;
      if (m_cnt == N) begin
        avg = m_acc / N;
        m_acc = 0;
        m_cnt = 0;
        if (!m_seeded) begin
          m_dc_acc = avg * (1 << S);
          m_seeded = 1;
        end
        dc = m_dc_acc / (1 << S);
        o  = avg - dc;
        s  = 1'b0;
        if (o > (1 << (W-1)) - 1) begin
          o = (1 << (W-1)) - 1;
          s = 1'b1;
        end else if (o < -(1 << (W-1))) begin
          o = -(1 << (W-1));
          s = 1'b1;
        end
        m_dc_acc = m_dc_acc + avg - dc;
        exp_q.push_back('{val: o[W-1:0], sat: s, edge_ix: 32'(edge_cnt + 2)});
      end
    end
    @(posedge clk);
    #1;
    edge_cnt++;
    if (audio_valid && audio_ready)
      obs_q.push_back('{val: audio_out, sat: sat, edge_ix: 32'(edge_cnt - 1)});
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    model_clear();
    repeat (2) begin
      @(posedge clk);
      #1;
      edge_cnt++;
    end
    arst_n = 1'b1;
    base = edge_cnt;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      env_in    = W'($urandom);
      env_valid = 1'($urandom);
      @(posedge clk);
      #1;
      edge_cnt++;
      checks++;
      if ({audio_out, audio_valid, sat, overrun} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got out=%0h valid=%0b sat=%0b ovr=%0b, expected all 0",
                 audio_out, audio_valid, sat, overrun);
      end
    end
    model_clear();
    arst_n = 1'b1;
    base = edge_cnt;
  endtask

  task automatic test_constant();
    sample_t e;
    sample_t o;
    for (int k = 0; k < 200; k++) begin
      step(k < 3 * N, W'(1000));
      if (k < 65) begin
        checks++;
        if (audio_valid !== 1'b0) begin
          errors++;
          $display("FAIL const_early_valid: edge %0d got valid=%0b, expected 0", k, audio_valid);
        end
      end
      if (k == 65 || k == 129) begin
        checks++;
        if (audio_valid !== 1'b1) begin
          errors++;
          $display("FAIL const_pulse: edge %0d got valid=%0b, expected 1", k, audio_valid);
        end
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL const_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL const_out: got val=%0d sat=%0b edge=%0d, expected val=%0d sat=%0b edge=%0d",
                 $signed(o.val), o.sat, o.edge_ix, $signed(e.val), e.sat, e.edge_ix);
      end
    end
  endtask

  task automatic test_dc_step();
    sample_t e;
    sample_t o;
    obs_q.delete();
    exp_q.delete();
    for (int k = 0; k < 2 * N + 4; k++)
      step(k < 2 * N, W'(1256));
    checks++;
    if (obs_q[0].val !== W'(256)) begin
      errors++;
      $display("FAIL dc_step_first: got %0d, expected 256", $signed(obs_q[0].val));
    end
    checks++;
    if (obs_q[1].val !== W'(255)) begin
      errors++;
      $display("FAIL dc_step_second: got %0d, expected 255", $signed(obs_q[1].val));
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL dc_step_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL dc_step_out: got val=%0d sat=%0b edge=%0d, expected val=%0d sat=%0b edge=%0d",
                 $signed(o.val), o.sat, o.edge_ix, $signed(e.val), e.sat, e.edge_ix);
      end
    end
  endtask

  task automatic test_alternate();
    int first;
    first = -1;
    do_reset();
    for (int k = 0; k < 140; k++) begin
      step(k % 2 == 0, W'(1000));
      if (audio_valid && first < 0) first = edge_cnt - 1 - base;
    end
    checks++;
    if (first != 128) begin
      errors++;
      $display("FAIL alternate_latency: got first valid at edge %0d, expected 128", first);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL alternate_out: got %0d outputs val=%0d, expected 1 output val=0",
               obs_q.size(), $signed(obs_q[0].val));
    end
  endtask

  task automatic test_saturation();
    sample_t e;
    sample_t o;
    do_reset();
    for (int k = 0; k < 3 * N + 4; k++)
      step(k < 3 * N, (k >= N && k < 2 * N) ? W'(4095) : W'(0));
    checks++;
    if (obs_q[0].val !== W'(0) || obs_q[0].sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_seed: got val=%0d sat=%0b, expected val=0 sat=0",
               $signed(obs_q[0].val), obs_q[0].sat);
    end
    checks++;
    if (obs_q[1].val !== W'(2047) || obs_q[1].sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_clip: got val=%0d sat=%0b, expected val=2047 sat=1",
               $signed(obs_q[1].val), obs_q[1].sat);
    end
    checks++;
    if (obs_q[2].val !== W'(-15) || obs_q[2].sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_negative: got val=%0d sat=%0b, expected val=-15 sat=0",
               $signed(obs_q[2].val), obs_q[2].sat);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sat_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sat_out: got val=%0d sat=%0b edge=%0d, expected val=%0d sat=%0b edge=%0d",
                 $signed(o.val), o.sat, o.edge_ix, $signed(e.val), e.sat, e.edge_ix);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    audio_ready = 1'b0;
    for (int k = 0; k < 2 * N + 4; k++) begin
      step(k < 2 * N, (k < N) ? W'(1000) : W'(1256));
      if (k == 65) begin
        checks++;
        if (audio_valid !== 1'b1 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL overrun_first: got valid=%0b ovr=%0b, expected valid=1 ovr=0",
                   audio_valid, overrun);
        end
      end
    end
    checks++;
    if (overrun !== 1'b1 || audio_valid !== 1'b1 || audio_out !== W'(256)) begin
      errors++;
      $display("FAIL overrun_second: got ovr=%0b valid=%0b out=%0d, expected ovr=1 valid=1 out=256",
               overrun, audio_valid, $signed(audio_out));
    end
    audio_ready = 1'b1;
    step(1'b0, '0);
    checks++;
    if (audio_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got valid=%0b ovr=%0b, expected valid=0 ovr=1",
               audio_valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reset_overrun: got ovr=%0b, expected 0", overrun);
    end
    for (int k = 0; k < 130; k++) begin
      audio_ready = (k == 129);
      step(k < 2 * N, (k < N) ? W'(1000) : W'(1256));
    end
    checks++;
    if (audio_valid !== 1'b1 || overrun !== 1'b0 || audio_out !== W'(256)) begin
      errors++;
      $display("FAIL b2b_replace: got valid=%0b ovr=%0b out=%0d, expected valid=1 ovr=0 out=256",
               audio_valid, overrun, $signed(audio_out));
    end
    audio_ready = 1'b1;
    step(1'b0, '0);
    checks++;
    if (audio_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_consume: got valid=%0b ovr=%0b, expected valid=0 ovr=0",
               audio_valid, overrun);
    end
  endtask

  task automatic test_reset_midblock();
    int first;
    logic [W-1:0] first_val;
    first = -1;
    first_val = '1;
    do_reset();
    for (int k = 0; k < N + 4 + 30; k++)
      step(k < N || k >= N + 4, W'(1000));
    do_reset();
    for (int k = 0; k < 70; k++) begin
      step(1'b1, W'(2000));
      if (audio_valid && first < 0) begin
        first = edge_cnt - 1 - base;
        first_val = audio_out;
      end
    end
    checks++;
    if (first != 65) begin
      errors++;
      $display("FAIL midblock_latency: got first valid at edge %0d, expected 65", first);
    end
    checks++;
    if (first_val !== W'(0)) begin
      errors++;
      $display("FAIL midblock_reseed: got %0d, expected 0", $signed(first_val));
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL midblock_scoreboard: got %0d outputs val=%0d edge=%0d, expected 1 output edge=%0d",
               obs_q.size(), $signed(obs_q[0].val), obs_q[0].edge_ix, exp_q[0].edge_ix);
    end
  endtask

  initial begin
    arst_n      = 1'b0;
    env_in      = '0;
    env_valid   = 1'b0;
    audio_ready = 1'b1;
    #2;
    test_reset();
    test_constant();
    test_dc_step();
    test_alternate();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_midblock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/am_audio_decimator.md
AM_AUDIO_DECIMATOR -- requirements
Module: am_audio_decimator

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 12: width of the unsigned envelope input, equal to the AM demodulator output width.
REQ-002 SHALL have parameter DECIM_LOG2, default 6: decimation factor is 2^DECIM_LOG2 accepted samples.
REQ-003 SHALL have parameter DC_SHIFT, default 8: DC-tracker time constant is 2^DC_SHIFT decimated samples.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port arst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port env_in, input, INPUT_WIDTH bits: unsigned AM envelope sample.
REQ-007 SHALL have port env_valid, input, 1 bit: env_in is accepted on every edge where env_valid=1.
REQ-008 SHALL have port audio_out, output, INPUT_WIDTH bits: signed, DC-removed audio sample.
REQ-009 SHALL have port audio_valid, output, 1 bit: audio_out holds an unconsumed sample.
REQ-010 SHALL have port audio_ready, input, 1 bit: the consumer takes audio_out on an edge where audio_valid=1 and audio_ready=1.
REQ-011 SHALL have port sat, output, 1 bit: one-cycle pulse when the loaded sample was clipped.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag; an unconsumed sample was overwritten.

Function
REQ-013 SHALL accumulate accepted samples in an unsigned accumulator of width INPUT_WIDTH+DECIM_LOG2, with a DECIM_LOG2-bit sample counter.
REQ-014 SHALL, on the 2^DECIM_LOG2-th accepted sample, load avg = (acc + env_in) >> DECIM_LOG2, clear acc to 0 and wrap the counter to 0 on the same edge.
REQ-015 SHALL leave acc and the counter unchanged on edges with env_valid=0; gaps only stretch the block.
REQ-016 SHALL keep an unsigned DC accumulator dc_acc of width INPUT_WIDTH+DC_SHIFT; dc = dc_acc >> DC_SHIFT.
REQ-017 SHALL, one edge after avg loads, compute out = avg - dc (using dc before its update) at INPUT_WIDTH+1 signed bits, then update dc_acc <= dc_acc + avg - (dc_acc >> DC_SHIFT).
REQ-018 SHALL, on the first decimated sample after reset, seed dc_acc = avg << DC_SHIFT before computing out, so the first output is 0.
REQ-019 SHALL saturate out to the signed INPUT_WIDTH range [-2^(INPUT_WIDTH-1), 2^(INPUT_WIDTH-1)-1] and pulse sat on the same edge the clipped value loads.
REQ-020 SHALL load audio_out and set audio_valid=1 on the edge two cycles after the block-completing sample is accepted (latency 2).
REQ-021 SHALL clear audio_valid on a consume edge when no new sample loads on that edge.
REQ-022 SHALL, when a new sample loads while audio_valid=1 and audio_ready=0, overwrite audio_out, keep audio_valid=1 and set overrun=1 until reset.
REQ-023 SHALL, when a new sample loads on a consume edge, treat the old sample as consumed, load the new one, keep audio_valid=1 and leave overrun unchanged.

Reset
REQ-024 SHALL, while arst_n=0, force the following to 0: audio_out, audio_valid, sat, overrun, acc, counter, avg, dc_acc and the first-sample flag (flag re-armed).
REQ-025 SHALL discard any partial block when reset is asserted mid-block; after release the next output requires a full 2^DECIM_LOG2 new samples.

Verification (defaults, audio_ready=1 unless stated)
REQ-026 SHALL cover: arst_n=0 with random inputs -> all outputs 0; release -> audio_valid stays 0 for the first 65 edges.
REQ-027 SHALL cover: env_in=1000, env_valid=1 continuous from cycle 0 -> audio_valid pulses at cycles 65, 129, ... with audio_out=0 and sat=0.
REQ-028 SHALL cover: env_valid alternating 1/0, env_in=1000 -> first audio_valid at cycle 128 with value 0.
REQ-029 SHALL cover: settled at 1000, then whole blocks of 1256 -> outputs 256, 255 (dc_acc 256256 -> dc 1001), ...
REQ-030 SHALL cover: first block 0, then blocks of 4095 -> second output 2047 with sat=1; then block of 0 after seed 0 gives no clip.
REQ-031 SHALL cover two cases: audio_ready=0 across two outputs -> overrun=1 with audio_out equal to the second sample; and arst_n pulsed after 30 samples -> the next output comes 66 accepted samples after release and equals 0 (re-seeded).
